// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM data-memory controller.
//   state_t           : controller FSM encoding (IDLE / LOW / HIGH / DONE)
//   DEFAULT_BASE_ADDR : CPU byte address that maps to SRAM word 0
//   SRAM_DW           : SRAM data bus width
//   byte_to_word()    : CPU byte address -> 32-bit word index (wraps below base)
package sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;
  localparam int          SRAM_DW           = 16;

  // Unsigned subtract on purpose: addresses below the base wrap around.
  function automatic logic [31:0] byte_to_word(input logic [31:0] byte_addr,
                                               input logic [31:0] base);
    return (byte_addr - base) >> 2;
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter timing one 16-bit SRAM phase.
//   clk, rst : clock, asynchronous active-low reset
//   load     : preload WAIT_CYCLES (takes priority over en)
//   en       : count down, saturating at zero
//   last     : count is zero, i.e. this is the final cycle of the phase
module sram_wait_counter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic last
);

  localparam logic [3:0] PRELOAD = 4'(WAIT_CYCLES);

  logic [3:0] count_q;

  // NOTE: clocked state is written with <= so every register samples the
  // pre-edge values of its sources, whatever the order of the statements.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= PRELOAD;
    end else if (en && (count_q != 4'd0)) begin
      count_q <= count_q - 4'd1;
    end
  end

  assign last = (count_q == 4'd0);

endmodule

// File: rtl/sram_controller.sv
// Data-memory controller: turns one 32-bit CPU load/store into two 16-bit
// accesses to an asynchronous SRAM, low half first. ready drops while an
// access is in flight so the pipeline freezes.
//   clk, rst              : clock, asynchronous active-low reset
//   wr_en, rd_en          : store / load request (store wins if both set)
//   address, write_data   : CPU byte address and store data
//   read_data, ready      : load result, 0 = pipeline must freeze
//   sram_addr             : halfword address {word, half}
//   sram_dq_out/_oe/_in   : pad data out, output enable, data in
//   sram_we_n             : active-low write strobe
// Optional: define SRAM_WORD_BUFFER_EN for a one-entry word buffer that
// answers repeated reads of the last accessed word with zero latency.
module sram_controller
  import sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          WAIT_CYCLES = 1,
  parameter int          SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_we_n
);

  state_t             state_q, state_d;
  logic               cmd_write_q;
  logic [SRAM_AW-2:0] word_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic               request, hit, start;
  logic               cnt_load, cnt_en, last;
  logic               active;

  assign request = wr_en | rd_en;

`ifdef SRAM_WORD_BUFFER_EN
  logic        buf_valid_q;
  logic [31:0] buf_tag_q, buf_data_q, tag_q;

  assign hit = (state_q == ST_IDLE) && rd_en && !wr_en && buf_valid_q &&
               (buf_tag_q == byte_to_word(address, BASE_ADDR));
`else
  assign hit = 1'b0;
`endif

  assign start = (state_q == ST_IDLE) && request && !hit;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned (which would infer a latch).
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_LOW;
          cnt_load = 1'b1;
        end
      end
      ST_LOW: begin
        cnt_en = 1'b1;
        if (last) begin
          state_d  = ST_HIGH;
          cnt_load = 1'b1;
        end
      end
      ST_HIGH: begin
        cnt_en = 1'b1;
        if (last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait (
    .clk (clk),
    .rst (rst),
    .load(cnt_load),
    .en  (cnt_en),
    .last(last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_write_q <= 1'b0;
      word_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
    end else begin
      if (start) begin
        cmd_write_q <= wr_en;
        word_q      <= (SRAM_AW-1)'(byte_to_word(address, BASE_ADDR));
        wdata_q     <= write_data;
      end
      // Sample the pad on the final cycle of each phase, when it has had
      // the full wait time to settle.
      if (!cmd_write_q && last) begin
        if (state_q == ST_LOW)  rdata_q[15:0]  <= sram_dq_in;
        if (state_q == ST_HIGH) rdata_q[31:16] <= sram_dq_in;
      end
`ifdef SRAM_WORD_BUFFER_EN
      if (hit) rdata_q <= buf_data_q;
`endif
    end
  end

`ifdef SRAM_WORD_BUFFER_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
      tag_q       <= '0;
    end else begin
      if (start) tag_q <= byte_to_word(address, BASE_ADDR);
      if (state_q == ST_DONE) begin
        buf_valid_q <= 1'b1;
        buf_tag_q   <= tag_q;
        buf_data_q  <= cmd_write_q ? wdata_q : rdata_q;
      end
    end
  end

  assign read_data = hit ? buf_data_q : rdata_q;
`else
  assign read_data = rdata_q;
`endif

  assign ready = ~request | (state_q == ST_DONE) | hit;

  // Strobes decode straight from the asynchronously reset state register,
  // so asserting rst releases the bus without waiting for a clock edge.
  assign active      = (state_q == ST_LOW) || (state_q == ST_HIGH);
  assign sram_we_n   = ~(active & cmd_write_q);
  assign sram_dq_oe  = active & cmd_write_q;
  assign sram_addr   = {word_q, (state_q == ST_HIGH)};
  assign sram_dq_out = (state_q == ST_HIGH) ? wdata_q[31:16] : wdata_q[15:0];

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller. A scoreboard queue holds the
// expected SRAM write-bus cycles and the expected completions (read_data and
// latency); a negedge monitor pops and compares whenever the DUT strobes a
// write or raises ready while a request is pending. A second instance with
// WAIT_CYCLES=0 covers the zero-wait timing.
module tb_sram_controller;

  typedef struct {
    logic [17:0] addr;
    logic [15:0] data;
  } bus_t;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
  } done_t;

`ifdef SRAM_WORD_BUFFER_EN
  localparam int HIT_LAT = 0;
`else
  localparam int HIT_LAT = 5;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [31:0] address = '0, write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  logic        wr_en0 = 1'b0, rd_en0 = 1'b0;
  logic [31:0] address0 = '0, write_data0 = '0;
  logic [31:0] read_data0;
  logic        ready0;
  logic [17:0] sram_addr0;
  logic [15:0] sram_dq_out0, sram_dq_in0;
  logic        sram_dq_oe0, sram_we_n0;

  logic [15:0] mem [0:255];

  bus_t  exp_bus[$];
  done_t exp_done[$];
  int    checks = 0, errors = 0;
  int    cyc = 0, req_start = 0, done_cnt = 0;
  bit    mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_controller #(.WAIT_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
  );

  sram_controller #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en0), .rd_en(rd_en0), .address(address0),
    .write_data(write_data0), .read_data(read_data0), .ready(ready0),
    .sram_addr(sram_addr0), .sram_dq_out(sram_dq_out0), .sram_dq_oe(sram_dq_oe0),
    .sram_dq_in(sram_dq_in0), .sram_we_n(sram_we_n0)
  );

  // SRAM models: a small writable array for the main DUT, and a fixed
  // address-derived pattern for the zero-wait instance.
  assign sram_dq_in  = mem[sram_addr[7:0]];
  assign sram_dq_in0 = sram_addr0[15:0] ^ 16'hA5A5;

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      mem[2] <= 16'h1234;
      mem[3] <= 16'h5678;
      mem[6] <= 16'h7777;
      mem[7] <= 16'h8888;
    end else if (!sram_we_n) begin
      mem[sram_addr[7:0]] <= sram_dq_out;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares bus write cycles and completions against the queues.
  always @(negedge clk) begin
    bus_t  be;
    done_t de;
    if (mon_en && rst) begin
      if (!sram_we_n) begin
        if (exp_bus.size() == 0) begin
          check("bus_unexpected_write", {14'd0, sram_addr}, 32'hFFFF_FFFF);
        end else begin
          be = exp_bus.pop_front();
          check("bus_addr", {14'd0, sram_addr}, {14'd0, be.addr});
          check("bus_data", {16'd0, sram_dq_out}, {16'd0, be.data});
          check("bus_oe", {31'd0, sram_dq_oe}, 32'd1);
        end
      end
      if ((wr_en | rd_en) && ready) begin
        if (exp_done.size() == 0) begin
          check("done_unexpected", read_data, 32'hFFFF_FFFF);
        end else begin
          de = exp_done.pop_front();
          check("done_read_data", read_data, de.rdata);
          check("done_latency", cyc - req_start, de.lat);
        end
        req_start = cyc + 1;
        done_cnt++;
      end
    end
  end

  task automatic push_write(input logic [17:0] lo_addr, input logic [31:0] data);
    bus_t b;
    for (int i = 0; i < 2; i++) begin
      b.addr = lo_addr;
      b.data = data[15:0];
      exp_bus.push_back(b);
    end
    for (int i = 0; i < 2; i++) begin
      b.addr = lo_addr | 18'd1;
      b.data = data[31:16];
      exp_bus.push_back(b);
    end
  endtask

  task automatic push_done(input logic [31:0] rdata, input int lat);
    done_t d;
    d.rdata = rdata;
    d.lat   = lat;
    exp_done.push_back(d);
  endtask

  task automatic wait_done(input int target);
    int i = 0;
    while (done_cnt < target && i < 40) begin
      @(posedge clk);
      i++;
    end
    if (done_cnt < target) check("done_timeout", done_cnt, target);
    #1;
  endtask

  task automatic run_req(input bit wr, input bit rd, input logic [31:0] addr,
                         input logic [31:0] data);
    int target;
    target = done_cnt + 1;
    @(posedge clk);
    #1;
    wr_en = wr; rd_en = rd; address = addr; write_data = data;
    req_start = cyc;
    wait_done(target);
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int target;
    int start_cyc;
    bit got;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    check("rst_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("rst_addr", {14'd0, sram_addr}, 32'd0);
    check("rst_dq_out", {16'd0, sram_dq_out}, 32'd0);
    check("rst_read_data", read_data, 32'd0);
    rst = 1'b1;

    // Reset asserted in the middle of a write phase.
    @(posedge clk); #1;
    wr_en = 1'b1; address = 32'd1028; write_data = 32'hCAFE_F00D;
    @(posedge clk); #1;
    check("midwrite_we_n_active", {31'd0, sram_we_n}, 32'd0);
    rst = 1'b0;
    #1;
    check("midwrite_rst_we_n", {31'd0, sram_we_n}, 32'd1);
    check("midwrite_rst_oe", {31'd0, sram_dq_oe}, 32'd0);
    wr_en = 1'b0;
    #1;
    check("midwrite_rst_ready", {31'd0, ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", {31'd0, ready}, 32'd1);
    check("post_rst_we_n", {31'd0, sram_we_n}, 32'd1);
    mon_en = 1'b1;

    // Read preloaded words 2/3.
    push_done(32'h5678_1234, 5);
    run_req(1'b0, 1'b1, 32'd1028, 32'd0);

    // Write: halfwords 2 then 3; read_data unchanged.
    push_write(18'd2, 32'hDEAD_BEEF);
    push_done(32'h5678_1234, 5);
    run_req(1'b1, 1'b0, 32'd1028, 32'hDEAD_BEEF);

    // Read back what was written.
    push_done(32'hDEAD_BEEF, HIT_LAT);
    run_req(1'b0, 1'b1, 32'd1028, 32'd0);

    // wr_en and rd_en together: the write wins.
    push_write(18'd4, 32'h0BAD_F00D);
    push_done(32'hDEAD_BEEF, 5);
    run_req(1'b1, 1'b1, 32'd1032, 32'h0BAD_F00D);

    // Address below base wraps to the top of the SRAM.
    push_write(18'h3FFFE, 32'h1111_2222);
    push_done(32'hDEAD_BEEF, 5);
    run_req(1'b1, 1'b0, 32'd1020, 32'h1111_2222);

    // Byte offset bits are ignored.
    push_done(32'h1111_2222, HIT_LAT);
    run_req(1'b0, 1'b1, 32'd1021, 32'd0);

    // Back-to-back: request held through DONE, new address in the IDLE cycle.
    push_done(32'h0BAD_F00D, 5);
    push_done(32'hDEAD_BEEF, 5);
    target = done_cnt + 2;
    @(posedge clk); #1;
    rd_en = 1'b1; address = 32'd1032;
    req_start = cyc;
    wait_done(target - 1);
    address = 32'd1028;
    wait_done(target);
    rd_en = 1'b0;

    // Word buffer: write then read the same word, then a different word.
    push_write(18'd4, 32'h1357_9BDF);
    push_done(32'hDEAD_BEEF, 5);
    run_req(1'b1, 1'b0, 32'd1032, 32'h1357_9BDF);
    push_done(32'h1357_9BDF, HIT_LAT);
    run_req(1'b0, 1'b1, 32'd1032, 32'd0);
    push_done(32'h8888_7777, 5);
    run_req(1'b0, 1'b1, 32'd1036, 32'd0);

    check("bus_queue_empty", exp_bus.size(), 32'd0);
    check("done_queue_empty", exp_done.size(), 32'd0);
    mon_en = 1'b0;

    // Zero-wait instance: read of 1028 -> halfwords 2/3, ready in cycle 3.
    @(posedge clk); #1;
    rd_en0 = 1'b1; address0 = 32'd1028;
    start_cyc = cyc;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ready0) got = 1'b1;
    end
    check("w0_ready_seen", {31'd0, got}, 32'd1);
    check("w0_latency", cyc - start_cyc, 32'd3);
    check("w0_read_data", read_data0, 32'hA5A6_A5A7);
    @(posedge clk); #1;
    rd_en0 = 1'b0;
    #1;
    check("w0_idle_ready", {31'd0, ready0}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
